if_stage_ctrl: RTL and testbench
================================

Name: if_stage_ctrl

Overview:
- Controls the instruction-fetch stage. Owns the PC and the IF/ID pipeline register.
- Runs a req/ack handshake to instruction memory.
- Handles branch/jump redirects from EX/MEM and load-use stalls from ID.
- Sits between the instruction memory port and the decode stage; feeds IF_ID_INSTR/IF_ID_NPC to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 15, cycles with IMEM_REQ high and no IMEM_ACK before the fetch error is raised (1..255).
- NOP_INSTR, 32'h0000_0000, value driven on IF_ID_INSTR when the IF/ID slot is invalid or flushed.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-low reset.
- EX_MEM_PCSrc  in  1  redirect request from EX/MEM; taken branch or jump.
- EX_MEM_NPC  in  32  redirect target, valid when EX_MEM_PCSrc=1.
- HZ_STALL  in  1  load-use stall from ID; freezes PC and IF/ID.
- IMEM_ACK  in  1  memory accepted the request; IMEM_RDATA is valid in the same cycle.
- IMEM_RDATA  in  32  fetched instruction.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  32  fetch address; stable while IMEM_REQ=1 and IMEM_ACK=0.
- PC  out  32  current fetch PC.
- IF_ID_INSTR  out  32  registered instruction to decode.
- IF_ID_NPC  out  32  registered fetch address + 4.
- IF_ID_VALID  out  1  IF/ID slot holds a real instruction.
- FLUSH_ID  out  1  one-cycle pulse that squashes ID/EX on a redirect.
- FETCH_ERR  out  1  sticky memory-timeout (or alignment) error.

Behaviour:
- Reset (RST=0 at an edge):
  - PC=RESET_PC, IMEM_REQ=0, IF_ID_INSTR=NOP_INSTR, IF_ID_NPC=0, IF_ID_VALID=0.
  - FLUSH_ID=0, FETCH_ERR=0; skid buffer, redirect-pending flag and timeout counter cleared.
  - State=BOOT. Reset overrides everything, including mid-handshake.
- States: BOOT, FETCH, HOLD, ERR.
- BOOT: IMEM_REQ=0 for one cycle, then -> FETCH.
- FETCH:
  - IMEM_REQ=1, IMEM_ADDR=PC.
  - On IMEM_ACK with no stall and no redirect: IF_ID_INSTR<=IMEM_RDATA, IF_ID_NPC<=PC+4, IF_ID_VALID<=1, PC<=PC+4. Stay in FETCH; back-to-back fetches give 1 instruction/cycle when ack is same-cycle.
  - No ack: IF/ID holds; timeout counter increments.
- Stall:
  - HZ_STALL=1 in FETCH with ack: data goes to the skid buffer (instr + PC+4), PC<=PC+4, -> HOLD.
  - HZ_STALL=1 without ack: the request stays outstanding and the IF/ID register holds.
- HOLD:
  - IMEM_REQ=0; IF/ID holds.
  - When HZ_STALL=0: IF/ID<=skid buffer, IF_ID_VALID=1, -> FETCH.
  - HZ_STALL=0 on the cycle of entry still costs the HOLD cycle (fixed 1-cycle bubble).
- Redirect (EX_MEM_PCSrc=1): highest priority after reset; overrides HZ_STALL.
  - IF_ID_VALID<=0, IF_ID_INSTR<=NOP_INSTR, FLUSH_ID<=1 for exactly one cycle, skid buffer discarded.
  - No outstanding request (HOLD, or FETCH with ack this cycle): PC<=EX_MEM_NPC, -> FETCH.
  - Outstanding request without ack: IMEM_ADDR stays unchanged and the target is saved in a pending register. The next ack's data is dropped, then PC<=saved target.
  - A second redirect while one is pending overwrites the saved target.
  - Redirect and ack in the same cycle: the ack data is dropped.
- Timeout: counter resets on every ack, and whenever IMEM_REQ=0. On reaching TIMEOUT: -> ERR.
- ERR: IMEM_REQ=0, FETCH_ERR=1, IF_ID_VALID=0. Exit only by reset.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no error. PC[1:0] is always 0.

Optional Feature:
- Macro IF_STAGE_CTRL_ALIGN_CHECK_EN.
- Defined: a redirect with EX_MEM_NPC[1:0]!=0 does not load the PC, sets FETCH_ERR=1 and goes to ERR (the FLUSH_ID pulse still occurs).
- Undefined: EX_MEM_NPC[1:0] is forced to 2'b00 when loaded and no error is raised.

Test Plan:
- Reset, then IMEM_ACK tied high with RDATA=addr^32'hA5A5_A5A5 -> IMEM_REQ rises the cycle after BOOT. IF_ID_NPC shows 4,8,12 on consecutive cycles with IF_ID_VALID=1.
- Ack latency 2 (ack on 3rd cycle of each request) -> IMEM_ADDR stable during the wait; one instruction per 3 cycles; PC steps 0→4→8.
- HZ_STALL=1 for 3 cycles with ack during the stall -> IF/ID frozen, IMEM_REQ=0 in HOLD. Buffered instruction appears the cycle after HZ_STALL falls; no instruction lost or duplicated.
- PCSrc=1, NPC=32'h100 while a request to 0x8 is outstanding; ack 2 cycles later -> FLUSH_ID one cycle, IMEM_ADDR stays 0x8, data at 0x8 dropped, next IMEM_ADDR=0x100.
- IMEM_ACK held low -> FETCH_ERR=1 exactly TIMEOUT(15) cycles after IMEM_REQ rises, IMEM_REQ=0. RST=0 for one edge clears FETCH_ERR and PC=RESET_PC.
- Redirect to 32'h102 -> with the macro: FETCH_ERR=1; without: PC=32'h100. Separately, PC=32'hFFFF_FFFC with ack -> PC=0.

Source files
------------

// File: rtl/if_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage_ctrl
//  Purpose  : Instruction-fetch stage controller. Owns the PC and the IF/ID
//             pipeline register, runs a req/ack handshake to instruction
//             memory, absorbs load-use stalls through a one-entry skid
//             buffer, handles EX/MEM redirects (including redirects that
//             arrive while a request is still outstanding) and raises a
//             sticky error when memory does not answer in time.
//  Options  : IF_STAGE_CTRL_ALIGN_CHECK_EN - when defined, a misaligned
//             redirect target is reported through FETCH_ERR instead of
//             being silently word-aligned.
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 15,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EX_MEM_PCSrc,
    input  logic [31:0] EX_MEM_NPC,
    input  logic        HZ_STALL,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_INSTR,
    output logic [31:0] IF_ID_NPC,
    output logic        IF_ID_VALID,
    output logic        FLUSH_ID,
    output logic        FETCH_ERR
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    // Last counter value before the timeout fires; reaching TIMEOUT idle
    // request cycles is detected one count early so ERR is entered on the
    // TIMEOUT-th edge.
    localparam logic [7:0]  TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [31:0] PC_RST_VAL = RESET_PC & ~32'h3;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        req_q;
    logic [31:0] instr_q;
    logic [31:0] npc_q;
    logic        valid_q;
    logic        flush_q;
    logic        err_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_npc_q;
    logic        pend_q;
    logic [31:0] pend_tgt_q;
    logic [7:0]  tcnt_q;

    logic [31:0] pc_plus4;
    logic [31:0] redir_tgt;
    logic        redir_bad;

    // Sequential address, word-aligned redirect target and alignment fault.
    always_comb begin
        pc_plus4  = pc_q + 32'd4;
        redir_tgt = EX_MEM_NPC & ~32'h3;
`ifdef IF_STAGE_CTRL_ALIGN_CHECK_EN
        redir_bad = (EX_MEM_NPC[1:0] != 2'b00);
`else
        redir_bad = 1'b0;
`endif
    end

    // Fetch FSM: PC, handshake, IF/ID register, skid buffer, redirect and
    // timeout tracking. Redirect outranks stall; reset outranks everything.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= S_BOOT;
            pc_q         <= PC_RST_VAL;
            req_q        <= 1'b0;
            instr_q      <= NOP_INSTR;
            npc_q        <= 32'h0;
            valid_q      <= 1'b0;
            flush_q      <= 1'b0;
            err_q        <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_npc_q   <= 32'h0;
            pend_q       <= 1'b0;
            pend_tgt_q   <= 32'h0;
            tcnt_q       <= 8'd0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                S_BOOT: begin
                    tcnt_q <= 8'd0;
                    if (EX_MEM_PCSrc) begin
                        flush_q <= 1'b1;
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                        if (redir_bad) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            pc_q    <= redir_tgt;
                            state_q <= S_FETCH;
                            req_q   <= 1'b1;
                        end
                    end else begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (EX_MEM_PCSrc) begin
                        // Squash whatever is in IF/ID; any ack data this
                        // cycle belongs to the wrong path and is dropped.
                        flush_q <= 1'b1;
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                        if (redir_bad) begin
                            state_q <= S_ERR;
                            req_q   <= 1'b0;
                            err_q   <= 1'b1;
                            pend_q  <= 1'b0;
                            tcnt_q  <= 8'd0;
                        end else if (IMEM_ACK) begin
                            pc_q   <= redir_tgt;
                            pend_q <= 1'b0;
                            tcnt_q <= 8'd0;
                        end else begin
                            // Address must stay stable until the ack, so
                            // the target waits in the pending register.
                            pend_q     <= 1'b1;
                            pend_tgt_q <= redir_tgt;
                        end
                    end else if (IMEM_ACK) begin
                        tcnt_q <= 8'd0;
                        if (pend_q) begin
                            pc_q   <= pend_tgt_q;
                            pend_q <= 1'b0;
                        end else if (HZ_STALL) begin
                            skid_instr_q <= IMEM_RDATA;
                            skid_npc_q   <= pc_plus4;
                            pc_q         <= pc_plus4;
                            state_q      <= S_HOLD;
                            req_q        <= 1'b0;
                        end else begin
                            instr_q <= IMEM_RDATA;
                            npc_q   <= pc_plus4;
                            valid_q <= 1'b1;
                            pc_q    <= pc_plus4;
                        end
                    end

                    // Unanswered request cycle: count towards the timeout.
                    if (!IMEM_ACK && !(EX_MEM_PCSrc && redir_bad)) begin
                        if (tcnt_q == TMO_LAST) begin
                            state_q <= S_ERR;
                            req_q   <= 1'b0;
                            err_q   <= 1'b1;
                            valid_q <= 1'b0;
                            instr_q <= NOP_INSTR;
                            pend_q  <= 1'b0;
                            tcnt_q  <= 8'd0;
                        end else begin
                            tcnt_q <= tcnt_q + 8'd1;
                        end
                    end
                end

                S_HOLD: begin
                    tcnt_q <= 8'd0;
                    if (EX_MEM_PCSrc) begin
                        // Skid contents are discarded simply by not using them.
                        flush_q <= 1'b1;
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                        if (redir_bad) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            pc_q    <= redir_tgt;
                            state_q <= S_FETCH;
                            req_q   <= 1'b1;
                        end
                    end else if (!HZ_STALL) begin
                        instr_q <= skid_instr_q;
                        npc_q   <= skid_npc_q;
                        valid_q <= 1'b1;
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end
                end

                default: begin
                    // S_ERR: parked until reset.
                    req_q   <= 1'b0;
                    err_q   <= 1'b1;
                    valid_q <= 1'b0;
                    instr_q <= NOP_INSTR;
                    tcnt_q  <= 8'd0;
                end
            endcase
        end
    end

    assign IMEM_REQ    = req_q;
    assign IMEM_ADDR   = pc_q;
    assign PC          = pc_q;
    assign IF_ID_INSTR = instr_q;
    assign IF_ID_NPC   = npc_q;
    assign IF_ID_VALID = valid_q;
    assign FLUSH_ID    = flush_q;
    assign FETCH_ERR   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage_ctrl
//  Purpose  : Directed self-checking bench for if_stage_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage_ctrl;

    localparam logic [31:0] XORK = 32'hA5A5_A5A5;

    logic        CLK;
    logic        RST;
    logic        EX_MEM_PCSrc;
    logic [31:0] EX_MEM_NPC;
    logic        HZ_STALL;
    logic        IMEM_ACK;
    logic [31:0] IMEM_RDATA;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] PC;
    logic [31:0] IF_ID_INSTR;
    logic [31:0] IF_ID_NPC;
    logic        IF_ID_VALID;
    logic        FLUSH_ID;
    logic        FETCH_ERR;

    int n_chk;
    int n_err;

    if_stage_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .EX_MEM_PCSrc (EX_MEM_PCSrc),
        .EX_MEM_NPC   (EX_MEM_NPC),
        .HZ_STALL     (HZ_STALL),
        .IMEM_ACK     (IMEM_ACK),
        .IMEM_RDATA   (IMEM_RDATA),
        .IMEM_REQ     (IMEM_REQ),
        .IMEM_ADDR    (IMEM_ADDR),
        .PC           (PC),
        .IF_ID_INSTR  (IF_ID_INSTR),
        .IF_ID_NPC    (IF_ID_NPC),
        .IF_ID_VALID  (IF_ID_VALID),
        .FLUSH_ID     (FLUSH_ID),
        .FETCH_ERR    (FETCH_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction memory contents: a fixed function of the address.
    always_comb IMEM_RDATA = IMEM_ADDR ^ XORK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle before sampling / driving.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reset edge, then the BOOT edge: leaves the DUT in FETCH with REQ high.
    task automatic do_reset();
        RST = 1'b0;
        step();
        RST = 1'b1;
        step();
    endtask

    initial begin
        n_chk        = 0;
        n_err        = 0;
        RST          = 1'b0;
        EX_MEM_PCSrc = 1'b0;
        EX_MEM_NPC   = 32'h0;
        HZ_STALL     = 1'b0;
        IMEM_ACK     = 1'b0;
        #2;

        // ---- Reset state -------------------------------------------------
        step();
        check("rst_pc",    PC,          32'h0);
        check("rst_req",   {31'b0, IMEM_REQ},    32'h0);
        check("rst_valid", {31'b0, IF_ID_VALID}, 32'h0);
        check("rst_instr", IF_ID_INSTR, 32'h0);
        check("rst_npc",   IF_ID_NPC,   32'h0);
        check("rst_flush", {31'b0, FLUSH_ID},    32'h0);
        check("rst_err",   {31'b0, FETCH_ERR},   32'h0);
        RST      = 1'b1;
        IMEM_ACK = 1'b1;
        step();
        check("boot_req", {31'b0, IMEM_REQ}, 32'h1);
        check("boot_pc",  PC, 32'h0);

        // ---- Back-to-back fetches with same-cycle ack -------------------
        for (int i = 1; i <= 3; i++) begin
            step();
            check("b2b_npc",   IF_ID_NPC, 32'(4 * i));
            check("b2b_instr", IF_ID_INSTR, 32'(4 * (i - 1)) ^ XORK);
            check("b2b_valid", {31'b0, IF_ID_VALID}, 32'h1);
        end

        // ---- Ack latency 2 -----------------------------------------------
        do_reset();
        for (int i = 0; i < 3; i++) begin
            IMEM_ACK = 1'b0;
            step();
            check("lat_addr_w1", IMEM_ADDR, 32'(4 * i));
            step();
            check("lat_addr_w2", IMEM_ADDR, 32'(4 * i));
            IMEM_ACK = 1'b1;
            step();
            check("lat_npc", IF_ID_NPC, 32'(4 * i + 4));
            check("lat_pc",  PC,        32'(4 * i + 4));
        end
        IMEM_ACK = 1'b0;

        // ---- Load-use stall with ack during the stall -------------------
        do_reset();
        IMEM_ACK = 1'b1;
        step();
        check("stl_pre_npc", IF_ID_NPC, 32'h4);
        HZ_STALL = 1'b1;
        step();
        check("stl_hold_req", {31'b0, IMEM_REQ}, 32'h0);
        check("stl_hold_npc", IF_ID_NPC, 32'h4);
        check("stl_hold_pc",  PC,        32'h8);
        step();
        check("stl_hold2_req", {31'b0, IMEM_REQ}, 32'h0);
        check("stl_hold2_npc", IF_ID_NPC, 32'h4);
        step();
        check("stl_hold3_npc", IF_ID_NPC, 32'h4);
        HZ_STALL = 1'b0;
        step();
        check("stl_rel_npc",   IF_ID_NPC,   32'h8);
        check("stl_rel_instr", IF_ID_INSTR, 32'h4 ^ XORK);
        check("stl_rel_valid", {31'b0, IF_ID_VALID}, 32'h1);
        check("stl_rel_req",   {31'b0, IMEM_REQ},    32'h1);
        step();
        check("stl_next_npc",   IF_ID_NPC,   32'hC);
        check("stl_next_instr", IF_ID_INSTR, 32'h8 ^ XORK);

        // ---- Redirect while a request is outstanding --------------------
        do_reset();
        IMEM_ACK = 1'b1;
        step();
        step();
        check("rdp_pre_addr", IMEM_ADDR, 32'h8);
        IMEM_ACK     = 1'b0;
        EX_MEM_PCSrc = 1'b1;
        EX_MEM_NPC   = 32'h100;
        step();
        EX_MEM_PCSrc = 1'b0;
        check("rdp_flush", {31'b0, FLUSH_ID},    32'h1);
        check("rdp_addr",  IMEM_ADDR,            32'h8);
        check("rdp_valid", {31'b0, IF_ID_VALID}, 32'h0);
        check("rdp_instr", IF_ID_INSTR,          32'h0);
        step();
        check("rdp_flush_off", {31'b0, FLUSH_ID}, 32'h0);
        check("rdp_addr_wait", IMEM_ADDR, 32'h8);
        IMEM_ACK = 1'b1;
        step();
        check("rdp_new_addr", IMEM_ADDR, 32'h100);
        check("rdp_drop_vld", {31'b0, IF_ID_VALID}, 32'h0);
        check("rdp_drop_npc", IF_ID_NPC, 32'h8);
        step();
        check("rdp_tgt_npc",   IF_ID_NPC,   32'h104);
        check("rdp_tgt_instr", IF_ID_INSTR, 32'h100 ^ XORK);
        check("rdp_tgt_valid", {31'b0, IF_ID_VALID}, 32'h1);

        // ---- Timeout -----------------------------------------------------
        do_reset();
        IMEM_ACK = 1'b0;
        for (int i = 1; i <= 14; i++) step();
        check("tmo_err_early", {31'b0, FETCH_ERR}, 32'h0);
        check("tmo_req_early", {31'b0, IMEM_REQ},  32'h1);
        step();
        check("tmo_err", {31'b0, FETCH_ERR}, 32'h1);
        check("tmo_req", {31'b0, IMEM_REQ},  32'h0);
        step();
        check("tmo_sticky", {31'b0, FETCH_ERR}, 32'h1);
        RST = 1'b0;
        step();
        RST = 1'b1;
        check("tmo_rst_err", {31'b0, FETCH_ERR}, 32'h0);
        check("tmo_rst_pc",  PC, 32'h0);

        // ---- Misaligned redirect ----------------------------------------
        do_reset();
        IMEM_ACK     = 1'b1;
        EX_MEM_PCSrc = 1'b1;
        EX_MEM_NPC   = 32'h102;
        step();
        EX_MEM_PCSrc = 1'b0;
        check("mis_flush", {31'b0, FLUSH_ID}, 32'h1);
`ifdef IF_STAGE_CTRL_ALIGN_CHECK_EN
        check("mis_err", {31'b0, FETCH_ERR}, 32'h1);
        check("mis_req", {31'b0, IMEM_REQ},  32'h0);
`else
        check("mis_pc",  PC, 32'h100);
        check("mis_err", {31'b0, FETCH_ERR}, 32'h0);
`endif

        // ---- PC wrap at top of address space ----------------------------
        do_reset();
        IMEM_ACK     = 1'b1;
        EX_MEM_PCSrc = 1'b1;
        EX_MEM_NPC   = 32'hFFFF_FFFC;
        step();
        EX_MEM_PCSrc = 1'b0;
        check("wrap_tgt", PC, 32'hFFFF_FFFC);
        step();
        check("wrap_pc",    PC,        32'h0);
        check("wrap_npc",   IF_ID_NPC, 32'h0);
        check("wrap_instr", IF_ID_INSTR, 32'hFFFF_FFFC ^ XORK);
        check("wrap_err",   {31'b0, FETCH_ERR}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
